// File: rtl/sort_top.sv
// -----------------------------------------------------------------------------
// sort_top -- pipelined rank-based minimum sorter
//
// Each cycle a vector of M unsigned N-bit keys is accepted. Three cycles later
// the W smallest keys of that vector appear on o_y_q in ascending order
// (o_y_q[0] holds the smallest). The pipeline has no handshake and no stall:
// a new vector may be applied every clock.
//
// Pipeline:
//   stage 1 (capture) : in_q   <= i_chi
//   stage 2 (rank)    : key_q  <= in_q, rank_q[i] <= number of keys that sort
//                       before in_q[i] (ties broken by lower index)
//   stage 3 (scatter) : o_y_q[r] <= the single key whose rank equals r
//
// Ports:
//   clk    in   1        single clock, all state updates on the rising edge
//   rst_n  in   1        synchronous reset, ACTIVE-HIGH despite the name
//                        (name kept for compatibility with the codebase)
//   i_chi  in   [M-1:0][N-1:0]  unsorted input keys, element k = i_chi[k]
//   o_y_q  out  [W-1:0][N-1:0]  registered sorted output, ascending with index
//
// Parameters (defaults taken from sort_pkg):
//   M  number of input keys per vector
//   N  key width in bits (unsigned)
//   W  number of output keys, legal range 1..M
//
// Build option:
//   SORT_DESCEND_EN  when defined the rank compare becomes greater-than, so
//                    o_y_q[0] is the largest key and the outputs are the W
//                    largest keys in descending order. Latency, reset and
//                    ports are unchanged.
// -----------------------------------------------------------------------------

package sort_pkg;
    localparam int M = 4;
    localparam int N = 4;
    localparam int W = 4;
endpackage

module sort_top #(
    parameter int M = sort_pkg::M,
    parameter int N = sort_pkg::N,
    parameter int W = sort_pkg::W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [M-1:0][N-1:0]   i_chi,
    output logic [W-1:0][N-1:0]   o_y_q
);

    // Rank width: enough to encode 0..M-1, never narrower than one bit.
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    // -------------------------------------------------------------------------
    // Stage 1: capture
    // -------------------------------------------------------------------------
    logic [M-1:0][N-1:0] in_q;

    // Reset takes priority over the data path, so an X on i_chi while reset
    // is held never reaches any register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= i_chi;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: rank
    // -------------------------------------------------------------------------
    // Every key is compared with every other key in parallel. Key j "beats"
    // key i when it must be placed ahead of i in the output order:
    //   - strictly smaller (strictly larger in the descending build), or
    //   - equal value and a lower index.
    // The index tie-break makes the sort stable and guarantees that the M
    // ranks are a permutation of 0..M-1, which the scatter stage relies on.
    logic [M-1:0][RW-1:0] rank_d;

    always_comb begin
        rank_d = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < M; j++) begin
                if (j != i) begin
`ifdef SORT_DESCEND_EN
                    if ((in_q[j] > in_q[i]) || ((in_q[j] == in_q[i]) && (j < i))) begin
                        rank_d[i] = rank_d[i] + RW'(1);
                    end
`else
                    if ((in_q[j] < in_q[i]) || ((in_q[j] == in_q[i]) && (j < i))) begin
                        rank_d[i] = rank_d[i] + RW'(1);
                    end
`endif
                end
            end
        end
    end

    logic [M-1:0][N-1:0]  key_q;
    logic [M-1:0][RW-1:0] rank_q;

    // Keys travel with their ranks so the scatter stage sees a matched pair.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            key_q  <= '0;
            rank_q <= '0;
        end else begin
            key_q  <= in_q;
            rank_q <= rank_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: scatter
    // -------------------------------------------------------------------------
    // Output slot r collects the key whose rank equals r. Because ranks are
    // unique exactly one key hits each slot, so a plain AND-OR mux is enough
    // and no priority logic is needed. Keys with rank >= W match no slot and
    // are dropped.
    //
    // Note: after reset key_q and rank_q are all zero, so every key claims
    // slot 0; since all those keys are zero the OR still yields zero.
    logic [W-1:0][N-1:0] y_d;

    always_comb begin
        y_d = '0;
        for (int r = 0; r < W; r++) begin
            for (int i = 0; i < M; i++) begin
                if (rank_q[i] == RW'(r)) begin
                    y_d[r] = y_d[r] | key_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            o_y_q <= '0;
        end else begin
            o_y_q <= y_d;
        end
    end

endmodule

// File: tb/tb_sort_top.sv
// -----------------------------------------------------------------------------
// tb_sort_top -- self-checking bench for sort_top
//
// Two instances share the same stimulus: u_dut with the package defaults
// (M=4, N=4, W=4, full sort) and u_dut_w2 with W=2 (two smallest only).
// Every driven vector pushes its fully sorted expectation into exp_q; three
// cycles later that entry is popped and compared with both instances.
// Reset cycles replace the pending entries with zeros, which is what the
// cleared pipeline must emit.
// -----------------------------------------------------------------------------

module tb_sort_top;

    localparam int M  = sort_pkg::M;
    localparam int N  = sort_pkg::N;
    localparam int W  = sort_pkg::W;
    localparam int W2 = 2;
    localparam int LAT = 3;

    typedef logic [M-1:0][N-1:0] vec_t;

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic rst_n;
    vec_t i_chi;
    logic [W-1:0][N-1:0]  o_y_q;
    logic [W2-1:0][N-1:0] o_y2_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sort_top #(.M(M), .N(N), .W(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_chi (i_chi),
        .o_y_q (o_y_q)
    );

    sort_top #(.M(M), .N(N), .W(W2)) u_dut_w2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_chi (i_chi),
        .o_y_q (o_y2_q)
    );

    // ---------------------------------------------------------------- scoreboard
    logic [M*N-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference: stable insertion sort, element 0 first in the output order.
    function automatic vec_t model(input vec_t v);
        logic [N-1:0] a[M];
        logic [N-1:0] t;
        vec_t r;
        for (int k = 0; k < M; k++) a[k] = v[k];
        for (int i = 1; i < M; i++) begin
            for (int j = i; j > 0; j--) begin
`ifdef SORT_DESCEND_EN
                if (a[j] > a[j-1]) begin
`else
                if (a[j] < a[j-1]) begin
`endif
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
            end
        end
        for (int k = 0; k < M; k++) r[k] = a[k];
        return r;
    endfunction

    task automatic compare_out(input string name, input vec_t exp_v);
        logic [W-1:0][N-1:0]  e1;
        logic [W2-1:0][N-1:0] e2;
        e1 = exp_v[W-1:0];
        e2 = exp_v[W2-1:0];
        checks++;
        if (o_y_q !== e1) begin
            errors++;
            $display("FAIL %s full: got %h expected %h at %0t", name, o_y_q, e1, $time);
        end
        checks++;
        if (o_y2_q !== e2) begin
            errors++;
            $display("FAIL %s w2: got %h expected %h at %0t", name, o_y2_q, e2, $time);
        end
    endtask

    // ---------------------------------------------------------------- driver
    // One call = one clock. At the falling edge the oldest pending expectation
    // (driven LAT cycles earlier) is checked, then the new input is applied.
    task automatic do_cycle(input string name, input vec_t v, input vec_t exp_v, input logic rst_v);
        vec_t e;
        @(negedge clk);
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            compare_out(name, e);
        end
        rst_n = rst_v;
        if (rst_v) begin
            i_chi = 'x;
            exp_q.delete();
            for (int k = 0; k < LAT; k++) exp_q.push_back('0);
        end else begin
            i_chi = v;
            exp_q.push_back(exp_v);
        end
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        vec_t vin;
        vec_t exp;
    } vec_rec_t;

    vec_rec_t tbl[6];
    vec_t rv;

    initial begin
        // Literals written i_chi[3..0]; expected written o_y_q[3..0].
        tbl[0].vin = {4'h6, 4'h0, 4'h5, 4'h7};
        tbl[1].vin = {4'h3, 4'h3, 4'h1, 4'h3};
        tbl[2].vin = {4'hF, 4'hE, 4'hD, 4'hC};
        tbl[3].vin = {4'h0, 4'h1, 4'h2, 4'h3};
        tbl[4].vin = {4'h8, 4'h8, 4'h8, 4'h8};
        tbl[5].vin = {4'h9, 4'h2, 4'h7, 4'h4};
`ifdef SORT_DESCEND_EN
        tbl[0].exp = {4'h0, 4'h5, 4'h6, 4'h7};
        tbl[1].exp = {4'h1, 4'h3, 4'h3, 4'h3};
        tbl[2].exp = {4'hC, 4'hD, 4'hE, 4'hF};
        tbl[3].exp = {4'h0, 4'h1, 4'h2, 4'h3};
        tbl[4].exp = {4'h8, 4'h8, 4'h8, 4'h8};
        tbl[5].exp = {4'h2, 4'h4, 4'h7, 4'h9};
`else
        tbl[0].exp = {4'h7, 4'h6, 4'h5, 4'h0};
        tbl[1].exp = {4'h3, 4'h3, 4'h3, 4'h1};
        tbl[2].exp = {4'hF, 4'hE, 4'hD, 4'hC};
        tbl[3].exp = {4'h3, 4'h2, 4'h1, 4'h0};
        tbl[4].exp = {4'h8, 4'h8, 4'h8, 4'h8};
        tbl[5].exp = {4'h9, 4'h7, 4'h4, 4'h2};
`endif

        // Reset with undriven keys: outputs must read zero.
        rst_n = 1'b1;
        i_chi = 'x;
        @(negedge clk);
        compare_out("reset_out", '0);
        do_cycle("reset", '0, '0, 1'b1);

        // Basic sort held for several cycles: output must settle and stay.
        for (int k = 0; k < 5; k++) do_cycle("basic_hold", tbl[0].vin, tbl[0].exp, 1'b0);

        // Table rows back to back, one per clock.
        for (int k = 0; k < 6; k++) do_cycle("table", tbl[k].vin, tbl[k].exp, 1'b0);

        // Reset for one cycle in the middle of the stream, then resume.
        do_cycle("pre_rst", tbl[2].vin, tbl[2].exp, 1'b0);
        do_cycle("mid_rst", '0, '0, 1'b1);
        for (int k = 0; k < 6; k++) do_cycle("post_rst", tbl[k].vin, tbl[k].exp, 1'b0);

        // Random vectors, biased toward narrow key ranges to create ties.
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < M; k++) begin
                if (n % 2 == 0) rv[k] = N'($urandom_range(0, 3));
                else            rv[k] = N'($urandom_range(0, (1 << N) - 1));
            end
            do_cycle("random", rv, model(rv), 1'b0);
        end

        // Drain the pipeline so every pushed expectation is compared.
        for (int k = 0; k < LAT; k++) begin
            for (int m = 0; m < M; m++) rv[m] = N'($urandom_range(0, (1 << N) - 1));
            do_cycle("drain", rv, model(rv), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sort_top.md
Name: sort_top

Overview:
- Pipelined combinational-rank sorter for the min_sort block.
- Each cycle it accepts a vector of M unsigned N-bit keys and produces the W smallest keys in ascending order.
- It is fully pipelined with fixed latency and no handshake: a new vector can be applied every clock.
- It sits between the key-generation logic and downstream consumers that need ordered minima.

Parameters:
- M, default 4: number of input keys per vector.
- N, default 4: key width in bits, unsigned.
- W, default 4: number of output keys; legal range 1..M.
- Defaults equal the sort_pkg constants; the package supplies M, N and W to the enclosing design.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  one clock; reset is synchronous and active-high. Port name kept as the codebase does; asserted = 1.
- i_chi  input  [M-1:0][N-1:0]  unsorted input keys; element k = i_chi[k]; sampled every cycle.
- o_y_q  output  [W-1:0][N-1:0]  registered sorted output; o_y_q[0] = smallest key, ascending with index.

Behaviour:
- Reset: when rst_n = 1 at a rising edge, clear all pipeline registers and o_y_q to 0.
  - While in reset, i_chi is ignored; X on the inputs must not propagate.
- Pipeline stage 1 (capture): register i_chi into in_q[M].
- Pipeline stage 2 (rank): for each element i, rank[i] = count of j where
  - in_q[j] < in_q[i], or
  - in_q[j] == in_q[i] and j < i.
- Rank properties:
  - Tie-break by lower index gives a stable sort and unique ranks 0..M-1.
  - Rank width is clog2(M), minimum 1 bit.
  - Register the ranks alongside the keys.
- Pipeline stage 3 (scatter): o_y_q[r] = the key whose rank == r, for r = 0..W-1.
  - Keys with rank >= W are discarded.
  - Exactly one key matches each r, so the select is one-hot OR-reduce with no priority encoder.
- Latency: a vector present at rising edge t appears on o_y_q after rising edge t+2 (3 register stages). Throughput: 1 vector/cycle.
- Continuous operation: o_y_q updates every cycle; if i_chi is held constant, o_y_q is stable from the third edge on.
- Arithmetic: unsigned compares only; no overflow cases; all-equal keys output unchanged in index order.
- Reset mid-operation: in-flight vectors are discarded. o_y_q reads 0 until the third rising edge after rst_n returns to 0 with valid input.
- W < M: only the W smallest keys are output; upper ranks are dropped.
- W = M: full sort.
- No internal state beyond the pipeline registers; no FSM.

Optional Feature:
- Macro SORT_DESCEND_EN.
- When defined, the compare in stage 2 becomes greater-than:
  - rank counts strictly larger keys, ties still broken by lower index;
  - o_y_q[0] is the largest key and the outputs are the W largest, descending.
- When undefined: ascending W-smallest behaviour as above.
- Latency, reset and ports are identical in both builds.

Test Plan:
- Reset check: hold rst_n=1 for 2 cycles with i_chi = X -> o_y_q == 0, no X on outputs.
- Basic sort: release reset, i_chi = {4'h6, 4'h0, 4'h5, 4'h7} (i_chi[3..0]) held -> from the 3rd edge on, o_y_q = {7,6,5,0}, i.e. o_y_q[0]=0, [1]=5, [2]=6, [3]=7.
- Ties/stability: i_chi = {4'h3, 4'h3, 4'h1, 4'h3} -> o_y_q = {3,3,3,1}; with SORT_DESCEND_EN -> {1,3,3,3}.
- Back-to-back throughput: apply {F,E,D,C}, then {0,1,2,3}, then {8,8,8,8} on consecutive cycles -> outputs on consecutive cycles are {F,E,D,C}, then {3,2,1,0}, then {8,8,8,8}, each with latency 3.
- Reset mid-stream: stream vectors, assert rst_n=1 for one cycle -> o_y_q = 0 at the next edge; the first post-reset vector appears exactly 3 edges after deassertion.
- W<M build (M=4, W=2): i_chi = {9,2,7,4} -> o_y_q[0]=2, o_y_q[1]=4.
